// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default widths for the IFU/LSU memory-port arbiter.
//   state_e : arbiter FSM states (IDLE, REQ, RESP)
//   owner_e : requester that owns the in-flight transaction (IFU, LSU)
//   GNT_*   : bit positions inside the one-hot grant vector
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie breaking).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    // Positions in the one-hot grant vector produced by mem_arb_pick.
    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant selection between fetch and load/store requests.
// Only meaningful while the arbiter is idle; the top gates the result.
//   ifu_valid  in  fetch request pending
//   lsu_valid  in  load/store request pending
//   last_grant in  requester accepted most recently (MEM_ARB_RR_EN only)
//   grant      out one-hot grant, bit GNT_IFU / GNT_LSU; zero if no request
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : a tie goes to the requester that was not granted last
//   undefined : a tie always goes to the LSU
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
`ifdef MEM_ARB_RR_EN
    input  owner_e     last_grant,
`endif
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        grant = 2'b00;
        if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
            if (last_grant == OWN_LSU) begin
                grant[GNT_IFU] = 1'b1;
            end else begin
                grant[GNT_LSU] = 1'b1;
            end
`else
            grant[GNT_LSU] = 1'b1;
`endif
        end else if (lsu_valid) begin
            grant[GNT_LSU] = 1'b1;
        end else if (ifu_valid) begin
            grant[GNT_IFU] = 1'b1;
        end
    end

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single memory port between instruction fetch (IFU) and load/store
// (LSU). One transaction at a time: IDLE -> REQ -> RESP -> IDLE. Every
// memory-side output and every response output is registered; only the two
// request readies are combinational (from the valids, while idle).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ifu_req_*             fetch request channel (valid/ready/addr)
//   ifu_resp_valid/data   fetch response, valid is a one-cycle pulse
//   lsu_req_*             load/store request channel (valid/ready/addr/wen/
//                         wdata/wmask)
//   lsu_resp_valid/data   load data or store acknowledge, one-cycle pulse
//   mem_req_*             memory request channel (valid/ready/addr/wen/
//                         wdata/wmask)
//   mem_resp_valid/data   memory response, only sampled in RESP
//   busy                  a transaction is in flight (state is not IDLE)
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin on ties, tracked by last_grant
//   undefined : fixed priority, LSU wins every tie
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,          state_d;
    owner_e              owner_q,          owner_d;
    logic [ADDR_W-1:0]   addr_q,           addr_d;
    logic                wen_q,            wen_d;
    logic [DATA_W-1:0]   wdata_q,          wdata_d;
    logic [MASK_W-1:0]   wmask_q,          wmask_d;
    logic                mem_req_valid_q,  mem_req_valid_d;
    logic                ifu_resp_valid_q, ifu_resp_valid_d;
    logic                lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DATA_W-1:0]   ifu_resp_data_q,  ifu_resp_data_d;
    logic [DATA_W-1:0]   lsu_resp_data_q,  lsu_resp_data_d;
`ifdef MEM_ARB_RR_EN
    owner_e              last_grant_q,     last_grant_d;
`endif

    logic [1:0]          grant;
    logic                idle;

    assign idle = (state_q == ST_IDLE);

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    mem_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .grant      (grant)
    );

    // The pick result already implies the matching valid, so a ready is only
    // ever raised for a requester that is actually asking.
    assign ifu_req_ready = idle && grant[GNT_IFU];
    assign lsu_req_ready = idle && grant[GNT_LSU];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        addr_d           = addr_q;
        wen_d            = wen_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        mem_req_valid_d  = mem_req_valid_q;
        ifu_resp_data_d  = ifu_resp_data_q;
        lsu_resp_data_d  = lsu_resp_data_q;
        // Response valids are pulses: they fall back to 0 unless set below.
        ifu_resp_valid_d = 1'b0;
        lsu_resp_valid_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d     = last_grant_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (grant[GNT_LSU]) begin
                    addr_d          = lsu_req_addr;
                    wen_d           = lsu_req_wen;
                    wdata_d         = lsu_req_wdata;
                    wmask_d         = lsu_req_wmask;
                    owner_d         = OWN_LSU;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
`ifdef MEM_ARB_RR_EN
                    last_grant_d    = OWN_LSU;
`endif
                end else if (grant[GNT_IFU]) begin
                    // Fetches are always reads with no bytes enabled.
                    addr_d          = ifu_req_addr;
                    wen_d           = 1'b0;
                    wdata_d         = '0;
                    wmask_d         = '0;
                    owner_d         = OWN_IFU;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
`ifdef MEM_ARB_RR_EN
                    last_grant_d    = OWN_IFU;
`endif
                end
            end

            ST_REQ: begin
                // Request registers stay untouched until the memory takes it.
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = ST_RESP;
                end
            end

            ST_RESP: begin
                if (mem_resp_valid) begin
                    if (owner_q == OWN_LSU) begin
                        lsu_resp_data_d  = mem_resp_data;
                        lsu_resp_valid_d = 1'b1;
                    end else begin
                        ifu_resp_data_d  = mem_resp_data;
                        ifu_resp_valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d         = ST_IDLE;
                mem_req_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the values from before this clock edge.
        if (!rst_n) begin
            // Reset drops any in-flight transaction and clears the datapath
            // registers so the outputs read 0 until the first response.
            state_q          <= ST_IDLE;
            owner_q          <= OWN_IFU;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            wdata_q          <= '0;
            wmask_q          <= '0;
            mem_req_valid_q  <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_resp_data_q  <= '0;
            lsu_resp_data_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q     <= OWN_IFU;
`endif
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            addr_q           <= addr_d;
            wen_q            <= wen_d;
            wdata_q          <= wdata_d;
            wmask_q          <= wmask_d;
            mem_req_valid_q  <= mem_req_valid_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            ifu_resp_data_q  <= ifu_resp_data_d;
            lsu_resp_data_q  <= lsu_resp_data_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q     <= last_grant_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_resp_data  = ifu_resp_data_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_resp_data  = lsu_resp_data_q;
    assign busy           = !idle;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs change 2 time units
// after the rising edge; outputs are observed from then until the next edge.
// Tie-breaking expectations follow MEM_ARB_RR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_resp_data;
    logic          lsu_req_valid, lsu_req_ready;
    logic [AW-1:0] lsu_req_addr;
    logic          lsu_req_wen;
    logic [DW-1:0] lsu_req_wdata;
    logic [MW-1:0] lsu_req_wmask;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_resp_data;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [MW-1:0] mem_req_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_data  (lsu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units past the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory accepts immediately, then responds one cycle later. Leaves the
    // bench at the cycle where the response pulse is visible.
    task automatic serve(input logic [63:0] rdata);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        step();
        mem_resp_valid = 1'b0;
    endtask

    // Hand-derived tie winner for the k-th accept of the tie test. The test
    // starts right after an IFU accept, so round-robin opens with the LSU.
    function automatic logic exp_lsu_wins(input int k);
`ifdef MEM_ARB_RR_EN
        return (k % 2) == 0;
`else
        return 1'b1 | (k < 0);
`endif
    endfunction

    initial begin
        rst_n          = 1'b0;
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        lsu_req_valid  = 1'b0;
        lsu_req_addr   = '0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = '0;
        lsu_req_wmask  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // ---------------- reset state ----------------
        #3;
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_req_addr",  mem_req_addr,       64'd0);
        check("rst_mem_req_wdata", mem_req_wdata,      64'd0);
        check("rst_mem_req_wmask", 64'(mem_req_wmask), 64'd0);
        check("rst_resp_valids",   64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        check("rst_resp_data",     ifu_resp_data | lsu_resp_data, 64'd0);
        check("rst_busy",          64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // ---------------- IFU fetch with memory wait ----------------
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 64'h0000_0000_8000_0000;
        #1;
        check("ifu_ready_idle", 64'({ifu_req_ready, lsu_req_ready}), 64'b10);
        step();
        ifu_req_valid = 1'b0;
        check("ifu_mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("ifu_mem_req_addr",  mem_req_addr, 64'h0000_0000_8000_0000);
        check("ifu_mem_req_wen",   64'(mem_req_wen), 64'd0);
        check("ifu_busy_req",      64'(busy), 64'd1);
        step();
        check("ifu_req_held",      64'(mem_req_valid), 64'd1);
        check("ifu_addr_held",     mem_req_addr, 64'h0000_0000_8000_0000);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("ifu_req_dropped",   64'(mem_req_valid), 64'd0);
        check("ifu_busy_resp",     64'(busy), 64'd1);
        step();
        check("ifu_no_early_pulse", 64'(ifu_resp_valid), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0010_0073_0000_0413;
        step();
        mem_resp_valid = 1'b0;
        check("ifu_resp_pulse",    64'(ifu_resp_valid), 64'd1);
        check("ifu_resp_data",     ifu_resp_data, 64'h0010_0073_0000_0413);
        check("ifu_lsu_quiet",     64'(lsu_resp_valid), 64'd0);
        check("ifu_busy_done",     64'(busy), 64'd0);
        step();
        check("ifu_pulse_end",     64'(ifu_resp_valid), 64'd0);
        check("ifu_data_hold",     ifu_resp_data, 64'h0010_0073_0000_0413);

        // ---------------- LSU store ----------------
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 64'h0000_0000_8000_1000;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 64'h1234_5678_8765_4321;
        lsu_req_wmask = 8'hFF;
        #1;
        check("st_ready_idle", 64'({ifu_req_ready, lsu_req_ready}), 64'b01);
        step();
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = '0;
        lsu_req_wmask = '0;
        check("st_mem_req_wen",   64'(mem_req_wen), 64'd1);
        check("st_mem_req_addr",  mem_req_addr, 64'h0000_0000_8000_1000);
        check("st_mem_req_wdata", mem_req_wdata, 64'h1234_5678_8765_4321);
        check("st_mem_req_wmask", 64'(mem_req_wmask), 64'hFF);
        serve(64'h0000_0000_0000_ACED);
        check("st_lsu_pulse",     64'(lsu_resp_valid), 64'd1);
        check("st_lsu_data",      lsu_resp_data, 64'h0000_0000_0000_ACED);
        check("st_ifu_quiet",     64'(ifu_resp_valid), 64'd0);
        check("st_ifu_data_kept", ifu_resp_data, 64'h0010_0073_0000_0413);
        step();
        check("st_pulse_end",     64'(lsu_resp_valid), 64'd0);

        // ---------------- memory response outside RESP ----------------
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        check("idle_resp_no_pulse", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        check("idle_resp_no_busy",  64'(busy), 64'd0);
        check("idle_resp_data",     lsu_resp_data, 64'h0000_0000_0000_ACED);
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_req_addr   = 64'h0000_0000_8000_0040;
        step();
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        step();
        check("req_resp_no_pulse", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        check("req_resp_still_req", 64'(mem_req_valid), 64'd1);
        check("req_resp_busy",     64'(busy), 64'd1);
        mem_resp_valid = 1'b0;
        serve(64'h1111_2222_3333_4444);
        check("req_resp_served",   ifu_resp_data, 64'h1111_2222_3333_4444);
        step();

        // ---------------- reset while in RESP ----------------
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 64'h0000_0000_8000_0080;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("rr_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rr_busy_async",  64'(busy), 64'd0);
        #2;
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        mem_resp_valid = 1'b0;
        check("rr_no_pulse", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        check("rr_idle",     64'(busy), 64'd0);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 64'h0000_0000_8000_00C0;
        step();
        ifu_req_valid = 1'b0;
        check("rr_next_addr", mem_req_addr, 64'h0000_0000_8000_00C0);
        serve(64'h5555_6666_7777_8888);
        check("rr_next_pulse", 64'(ifu_resp_valid), 64'd1);
        check("rr_next_data",  ifu_resp_data, 64'h5555_6666_7777_8888);
        step();

        // ---------------- both requesters valid every cycle ----------------
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 64'h0000_0000_0000_1000;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 64'h0000_0000_0000_2000;
        lsu_req_wen   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic        lw;
            logic [63:0] rd;
            lw = exp_lsu_wins(k);
            rd = 64'h0000_0000_0000_00A0 + 64'(k);
            #1;
            check($sformatf("tie%0d_ready", k), 64'({ifu_req_ready, lsu_req_ready}),
                  lw ? 64'b01 : 64'b10);
            step();
            check($sformatf("tie%0d_addr", k), mem_req_addr,
                  lw ? 64'h0000_0000_0000_2000 : 64'h0000_0000_0000_1000);
            check($sformatf("tie%0d_busy_ready", k), 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
            serve(rd);
            check($sformatf("tie%0d_pulses", k), 64'({ifu_resp_valid, lsu_resp_valid}),
                  lw ? 64'b01 : 64'b10);
            check($sformatf("tie%0d_data", k), lw ? lsu_resp_data : ifu_resp_data, rd);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        step();
        check("tie_end_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the core's single memory port between instruction fetch (IFU) and load/store (LSU). Each requester gets a valid/ready request channel and a response pulse. The block runs one transaction at a time through a 3-state FSM and registers every memory-side output. It sits between the core and the memory model that currently serves fetch and data through separate hard-wired paths.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; the byte mask is DATA_W/8 bits wide

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  fetch request accepted this cycle if valid
ifu_req_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  fetch data valid (one-cycle pulse)
ifu_resp_data  out  DATA_W  fetch data
lsu_req_valid  in  1  data request
lsu_req_ready  out  1  data request accepted this cycle if valid
lsu_req_addr  in  ADDR_W  data address
lsu_req_wen  in  1  1 = store, 0 = load
lsu_req_wdata  in  DATA_W  store data
lsu_req_wmask  in  DATA_W/8  store byte mask
lsu_resp_valid  out  1  load data / store acknowledge (one-cycle pulse)
lsu_resp_data  out  DATA_W  load data
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  ADDR_W  memory address
mem_req_wen  out  1  memory write enable
mem_req_wdata  out  DATA_W  memory write data
mem_req_wmask  out  DATA_W/8  memory byte mask
mem_resp_valid  in  1  memory response
mem_resp_data  in  DATA_W  memory read data
busy  out  1  a transaction is in flight (state is not IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, owner=IFU, last_grant=IFU. All outputs are 0; the address, data and mask registers are 0.
- States: IDLE, REQ, RESP.
- IDLE:
  - The ready output is high only for the requester chosen by the pick logic; the other ready is 0. Readies are combinational from the valids.
  - If the chosen requester's valid is high: latch addr, wen, wdata and wmask (wen=0, wmask=0 for IFU); set owner; go to REQ.
- REQ: mem_req_valid=1 from the registers. On mem_req_ready go to RESP, otherwise hold with all request outputs stable.
- RESP: on mem_resp_valid:
  - Register mem_resp_data into the owner's resp_data.
  - Pulse the owner's resp_valid for exactly the next cycle.
  - Go to IDLE.
- Both readies are 0 in REQ and RESP.
- A new request can be accepted in the same cycle that resp_valid pulses, so minimum spacing is 3 cycles per transaction plus memory latency.
- mem_resp_valid is ignored in IDLE and REQ. The memory must not respond in the same cycle as mem_req_ready.
- resp_data holds its last value until the next response to that requester.
- The non-owner's resp_valid never pulses.
- Stores also produce a resp_valid pulse; resp_data is then whatever mem_resp_data returned.
- Reset mid-transaction drops the transaction: no response pulse, FSM returns to IDLE.
- A requester may drop valid before ready; nothing is latched in that case.

Optional Feature:
MEM_ARB_RR_EN.
- Defined: round-robin. If both requesters are valid in IDLE, grant the one that is not last_grant. last_grant updates on every accept. After reset, the first tie goes to LSU.
- Undefined: fixed priority. LSU always wins a tie; last_grant is not implemented.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, REQ, RESP
  - owner enum: IFU, LSU
  - default widths
- One sub-module, mem_arb_pick: combinational grant selection from the two valids and last_grant, outputs a one-hot grant. Used only in IDLE.

Test Plan:
- IFU only, addr 0x80000000; memory gives ready at +1 cycle and response 0x00100073_00000413 two cycles later -> mem_req_valid stays high until ready, mem_req_wen=0, ifu_resp_valid one-cycle pulse with that data, lsu_resp_valid stays 0.
- LSU store, addr 0x80001000, wdata 0x1234567887654321, wmask 0xFF -> mem_req_wen=1 with the exact data and mask, lsu_resp_valid pulses once, ifu_resp_data unchanged.
- Both valid every cycle, fixed priority -> LSU granted on every accept, IFU starved.
- Both valid every cycle with MEM_ARB_RR_EN -> grants alternate LSU, IFU, LSU, IFU, with each response routed to the correct port.
- rst_n asserted while in RESP, then mem_resp_valid arrives -> no resp_valid pulse, busy=0, next IFU request is served normally.
- mem_resp_valid asserted in IDLE and in REQ -> ignored; no pulses, no state change.
